// File: rtl/mc_mem_responder.sv
// Memory-side responder for the multicycle CPU's shared instruction/data port.
// One transaction at a time, with a configurable read/write latency and registered responses.
module mc_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int RD_LATENCY  = 2,
  parameter int WR_LATENCY  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] RD_LOAD = 4'(RD_LATENCY - 1);
  localparam logic [3:0] WR_LOAD = 4'(WR_LATENCY - 1);

  generate
    if ((RD_LATENCY < 1) || (RD_LATENCY > 15) || (WR_LATENCY < 1) || (WR_LATENCY > 15) ||
        (DEPTH_WORDS < 1) || (DEPTH_WORDS > 1073741824)) begin : gBadParam
      $error("mc_mem_responder: parameter out of legal range");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } stateE;

  // A request is illegal when misaligned or when its word index falls past the array.
  function automatic logic addrErr(input logic [31:0] addr);
    logic misaligned;
    logic outOfRange;
    misaligned = (addr[1:0] != 2'b00);
    outOfRange = ({2'b00, addr[31:2]} >= 32'(DEPTH_WORDS));
    return misaligned || outOfRange;
  endfunction

  logic [31:0]      mem [DEPTH_WORDS];

  stateE            stateR;
  stateE            nextStateS;
  logic [3:0]       latCntR;
  logic [3:0]       nextLatCntS;

  logic             acceptS;
  logic             handshakeS;
  logic             reqErrS;
  logic             wrEnS;
  logic [IDX_W-1:0] wordIdxS;
  logic [3:0]       loadS;
  logic [31:0]      memRdS;

  logic             reqReadyR;
  logic             respValidR;
  logic [31:0]      respRdataR;
  logic             respErrR;
  logic             nextReqReadyS;
  logic             nextRespValidS;
  logic [31:0]      nextRespRdataS;
  logic             nextRespErrS;

  // Request decode: acceptance, handshake, address check and memory lookup.
  always_comb begin
    acceptS    = req_valid && reqReadyR && (stateR == IDLE);
    handshakeS = respValidR && resp_ready && (stateR == RESP);
    reqErrS    = addrErr(req_addr);
    wordIdxS   = req_addr[IDX_W+1:2];
    wrEnS      = acceptS && req_we && !reqErrS && rst_n;
    loadS      = req_we ? WR_LOAD : RD_LOAD;
    memRdS     = mem[wordIdxS];
  end

  // Storage array: never reset, so writes survive a mid-transaction reset.
  always_ff @(posedge clk) begin
    if (wrEnS) begin
      mem[wordIdxS] <= req_wdata;
    end
  end

  // State and latency counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateR  <= IDLE;
      latCntR <= 4'd0;
    end else begin
      stateR  <= nextStateS;
      latCntR <= nextLatCntS;
    end
  end

  // Next-state logic: a zero load skips WAIT so latency 1 answers on the following edge.
  always_comb begin
    nextStateS  = stateR;
    nextLatCntS = latCntR;
    case (stateR)
      IDLE: begin
        if (acceptS) begin
          nextLatCntS = loadS;
          if (loadS != 4'd0) begin
            nextStateS = WAIT;
          end else begin
            nextStateS = RESP;
          end
        end else begin
          nextStateS = IDLE;
        end
      end
      WAIT: begin
        if (latCntR <= 4'd1) begin
          nextStateS  = RESP;
          nextLatCntS = 4'd0;
        end else begin
          nextStateS  = WAIT;
          nextLatCntS = latCntR - 4'd1;
        end
      end
      RESP: begin
        if (handshakeS) begin
          nextStateS = IDLE;
        end else begin
          nextStateS = RESP;
        end
      end
      default: begin
        nextStateS  = IDLE;
        nextLatCntS = 4'd0;
      end
    endcase
  end

  // Output next-values: response payload captured at acceptance, cleared at handshake.
  always_comb begin
    nextReqReadyS  = (nextStateS == IDLE);
    nextRespValidS = (nextStateS == RESP);
    if (acceptS) begin
      nextRespErrS   = reqErrS;
      nextRespRdataS = (!req_we && !reqErrS) ? memRdS : 32'h0000_0000;
    end else if (handshakeS) begin
      nextRespErrS   = 1'b0;
      nextRespRdataS = 32'h0000_0000;
    end else begin
      nextRespErrS   = respErrR;
      nextRespRdataS = respRdataR;
    end
  end

  // Output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reqReadyR  <= 1'b1;
      respValidR <= 1'b0;
      respRdataR <= 32'h0000_0000;
      respErrR   <= 1'b0;
    end else begin
      reqReadyR  <= nextReqReadyS;
      respValidR <= nextRespValidS;
      respRdataR <= nextRespRdataS;
      respErrR   <= nextRespErrS;
    end
  end

  assign req_ready  = reqReadyR;
  assign resp_valid = respValidR;
  assign resp_rdata = respRdataR;
  assign resp_err   = respErrR;

  mc_mem_responder_chk uChk (
    .clk       (clk),
    .rst_n     (rst_n),
    .reqReady  (reqReadyR),
    .respValid (respValidR),
    .respReady (resp_ready),
    .respRdata (respRdataR),
    .respErr   (respErrR),
    .latCnt    (latCntR)
  );

endmodule

// Protocol checker for the responder: handshake exclusivity, stall stability, clear-on-take.
module mc_mem_responder_chk (
  input logic        clk,
  input logic        rst_n,
  input logic        reqReady,
  input logic        respValid,
  input logic        respReady,
  input logic [31:0] respRdata,
  input logic        respErr,
  input logic [3:0]  latCnt
);

  aExclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(reqReady && respValid));

  aStallHold: assert property (@(posedge clk) disable iff (!rst_n)
    (respValid && !respReady) |=> (respValid && $stable(respRdata) && $stable(respErr)));

  aClearOnTake: assert property (@(posedge clk) disable iff (!rst_n)
    (respValid && respReady) |=> (!respValid && (respRdata == 32'h0000_0000) && !respErr));

  aCntRange: assert property (@(posedge clk) disable iff (!rst_n)
    latCnt <= 4'd14);

endmodule

// File: tb/tb_mc_mem_responder.sv
// Self-checking bench: a default-parameter responder plus a fast-read/slow-write one.
module tb_mc_mem_responder;

  logic        clk;
  logic        rst_n;
  logic [1:0]  reqValid;
  logic [1:0]  reqReady;
  logic [1:0]  reqWe;
  logic [31:0] reqAddr   [2];
  logic [31:0] reqWdata  [2];
  logic [1:0]  respValid;
  logic [1:0]  respReady;
  logic [31:0] respRdata [2];
  logic [1:0]  respErr;

  int passCnt  = 0;
  int totalCnt = 0;

  typedef struct {
    bit          sel;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expRdata;
    bit          expErr;
    int          expLat;
    int          stall;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    bit          err;
    int          lat;
  } exp_t;

  exp_t sbq[$];

  mc_mem_responder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (reqValid[0]),
    .req_ready  (reqReady[0]),
    .req_we     (reqWe[0]),
    .req_addr   (reqAddr[0]),
    .req_wdata  (reqWdata[0]),
    .resp_valid (respValid[0]),
    .resp_ready (respReady[0]),
    .resp_rdata (respRdata[0]),
    .resp_err   (respErr[0])
  );

  mc_mem_responder #(.DEPTH_WORDS(1024), .RD_LATENCY(1), .WR_LATENCY(3)) dutF (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (reqValid[1]),
    .req_ready  (reqReady[1]),
    .req_we     (reqWe[1]),
    .req_addr   (reqAddr[1]),
    .req_wdata  (reqWdata[1]),
    .resp_valid (respValid[1]),
    .resp_ready (respReady[1]),
    .resp_rdata (respRdata[1]),
    .resp_err   (respErr[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end else begin
      passCnt++;
    end
  endtask

  // One full transaction: drive, wait for the response, optional stall, then take it.
  task automatic runTxn(input vec_t v);
    exp_t e;
    int   lat;
    bit   got;
    int   s;
    s = v.sel ? 1 : 0;
    @(negedge clk);
    chk("req_ready_idle", 32'(reqReady[s]), 32'd1);
    reqValid[s]  = 1'b1;
    reqWe[s]     = v.we;
    reqAddr[s]   = v.addr;
    reqWdata[s]  = v.wdata;
    respReady[s] = (v.stall == 0);
    e.rdata = v.expRdata;
    e.err   = v.expErr;
    e.lat   = v.expLat;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    reqValid[s] = 1'b0;
    reqAddr[s]  = 32'($urandom);
    reqWdata[s] = 32'($urandom);
    lat = 0;
    got = 1'b0;
    for (int n = 1; n <= 20 && !got; n++) begin
      @(negedge clk);
      if (respValid[s]) begin
        got = 1'b1;
        lat = n;
      end
    end
    e = sbq.pop_front();
    chk("latency", 32'(lat), 32'(e.lat));
    chk("resp_rdata", respRdata[s], e.rdata);
    chk("resp_err", 32'(respErr[s]), 32'(e.err));
    for (int k = 0; k < v.stall; k++) begin
      reqValid[s] = 1'b1;
      reqWe[s]    = 1'b1;
      reqAddr[s]  = v.addr;
      reqWdata[s] = 32'hBAD0_BAD0;
      @(negedge clk);
      chk("stall_valid", 32'(respValid[s]), 32'd1);
      chk("stall_rdata", respRdata[s], e.rdata);
      chk("stall_req_ready", 32'(reqReady[s]), 32'd0);
    end
    reqValid[s]  = 1'b0;
    respReady[s] = 1'b1;
    @(negedge clk);
    chk("taken_valid", 32'(respValid[s]), 32'd0);
    chk("taken_rdata", respRdata[s], 32'h0000_0000);
    chk("taken_ready", 32'(reqReady[s]), 32'd1);
  endtask

  initial begin
    vec_t vecs[$];
    exp_t e;
    int   hits;

    vecs.push_back('{1'b0, 1'b1, 32'h10,       32'hDEAD_BEEF, 32'h0,         1'b0, 1, 0});
    vecs.push_back('{1'b0, 1'b0, 32'h10,       32'h0,         32'hDEAD_BEEF, 1'b0, 2, 0});
    vecs.push_back('{1'b0, 1'b0, 32'h13,       32'h0,         32'h0,         1'b1, 2, 0});
    vecs.push_back('{1'b0, 1'b1, 32'h0,        32'hA5A5_0000, 32'h0,         1'b0, 1, 0});
    vecs.push_back('{1'b0, 1'b1, 32'h1000,     32'h1,         32'h0,         1'b1, 1, 0});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        32'h0,         32'hA5A5_0000, 1'b0, 2, 0});
    vecs.push_back('{1'b0, 1'b1, 32'hFFC,      32'h1234_5678, 32'h0,         1'b0, 1, 0});
    vecs.push_back('{1'b0, 1'b0, 32'hFFC,      32'h0,         32'h1234_5678, 1'b0, 2, 0});
    vecs.push_back('{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,        32'h0,         1'b1, 2, 0});
    vecs.push_back('{1'b0, 1'b1, 32'h11,       32'h77,        32'h0,         1'b1, 1, 0});
    vecs.push_back('{1'b0, 1'b0, 32'h10,       32'h0,         32'hDEAD_BEEF, 1'b0, 2, 5});
    vecs.push_back('{1'b0, 1'b0, 32'h10,       32'h0,         32'hDEAD_BEEF, 1'b0, 2, 0});
    vecs.push_back('{1'b0, 1'b1, 32'h0,        32'hCAFE_F00D, 32'h0,         1'b0, 1, 0});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        32'h0,         32'hCAFE_F00D, 1'b0, 2, 0});
    for (int i = 0; i < 4; i++) begin
      vecs.push_back('{1'b1, 1'b1, 32'h40 + 32'(4 * i), 32'h1000_0000 + 32'(i), 32'h0, 1'b0, 3, 0});
    end
    vecs.push_back('{1'b1, 1'b0, 32'h44,       32'h0,         32'h1000_0001, 1'b0, 1, 0});

    rst_n     = 1'b0;
    reqValid  = 2'b00;
    reqWe     = 2'b00;
    respReady = 2'b11;
    for (int i = 0; i < 2; i++) begin
      reqAddr[i]  = 32'h0;
      reqWdata[i] = 32'h0;
    end
    #22;
    for (int i = 0; i < 2; i++) begin
      chk("rst_resp_valid", 32'(respValid[i]), 32'd0);
      chk("rst_resp_rdata", respRdata[i], 32'h0);
      chk("rst_resp_err", 32'(respErr[i]), 32'd0);
      chk("rst_req_ready", 32'(reqReady[i]), 32'd1);
    end
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) runTxn(vecs[i]);

    // Back-to-back reads on the latency-1 instance with both valids held high.
    reqWe[1]     = 1'b0;
    respReady[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("b2b_req_ready", 32'(reqReady[1]), 32'd1);
      chk("b2b_idle_valid", 32'(respValid[1]), 32'd0);
      reqAddr[1]  = 32'h40 + 32'(4 * i);
      reqValid[1] = 1'b1;
      e.rdata = 32'h1000_0000 + 32'(i);
      e.err   = 1'b0;
      e.lat   = 1;
      sbq.push_back(e);
      @(negedge clk);
      e = sbq.pop_front();
      chk("b2b_resp_valid", 32'(respValid[1]), 32'd1);
      chk("b2b_rdata", respRdata[1], e.rdata);
      chk("b2b_busy", 32'(reqReady[1]), 32'd0);
    end
    reqValid[1] = 1'b0;

    // Reset pulsed while a write waits out its latency.
    @(negedge clk);
    reqValid[1] = 1'b1;
    reqWe[1]    = 1'b1;
    reqAddr[1]  = 32'h20;
    reqWdata[1] = 32'h55;
    @(posedge clk);
    #1;
    reqValid[1] = 1'b0;
    reqWe[1]    = 1'b0;
    @(negedge clk);
    chk("wait_no_valid", 32'(respValid[1]), 32'd0);
    chk("wait_not_ready", 32'(reqReady[1]), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(reqReady[1]), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    hits = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (respValid[1]) hits++;
    end
    chk("discarded_resp", 32'(hits), 32'd0);
    runTxn('{1'b1, 1'b0, 32'h20, 32'h0, 32'h55, 1'b0, 1, 0});
    runTxn('{1'b0, 1'b0, 32'h0,  32'h0, 32'hCAFE_F00D, 1'b0, 2, 0});

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/mc_mem_responder.md
MC_MEM_RESPONDER -- requirements
Module: mc_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit words stored.
REQ-002 SHALL have parameter RD_LATENCY, default 2: cycles from read acceptance to resp_valid; legal range 1..15.
REQ-003 SHALL have parameter WR_LATENCY, default 1: cycles from write acceptance to resp_valid; legal range 1..15.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port req_valid, input, 1: initiator presents a request.
REQ-007 SHALL have port req_ready, output, 1: responder can accept a request this cycle.
REQ-008 SHALL have port req_we, input, 1: 1 = write, 0 = read.
REQ-009 SHALL have port req_addr, input, 32: byte address.
REQ-010 SHALL have port req_wdata, input, 32: write data.
REQ-011 SHALL have port resp_valid, output, 1: response present.
REQ-012 SHALL have port resp_ready, input, 1: initiator takes the response.
REQ-013 SHALL have port resp_rdata, output, 32: read data; 0 for writes and errors.
REQ-014 SHALL have port resp_err, output, 1: request was misaligned or out of range.

Function
REQ-015 SHALL be the memory-side responder for the multicycle CPU's shared instruction/data memory port (Fetch, MemRd, MemWr states).
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-017 SHALL drive req_ready = 1 only in IDLE; a request is accepted on a rising edge with req_valid && req_ready.
REQ-018 SHALL, on acceptance, load latency counter with (req_we ? WR_LATENCY : RD_LATENCY) - 1 and go to WAIT if the loaded value is nonzero, else directly to RESP.
REQ-019 SHALL decrement the counter once per cycle in WAIT and go to RESP on the edge where the counter is 1 (resp_valid first high exactly LATENCY cycles after the acceptance edge).
REQ-020 SHALL flag error when req_addr[1:0] != 0 or req_addr[31:2] >= DEPTH_WORDS, evaluated at acceptance.
REQ-021 SHALL, for a legal write, commit req_wdata to word req_addr[31:2] on the acceptance edge; an erroneous write SHALL modify no word.
REQ-022 SHALL, for a legal read, capture word req_addr[31:2] into the response register on the acceptance edge; read-after-write to the same word in consecutive transactions SHALL return the new data.
REQ-023 SHALL register resp_rdata/resp_err at acceptance and hold them stable from entry to RESP until the response handshake.
REQ-024 SHALL hold resp_valid = 1 throughout RESP; on resp_valid && resp_ready return to IDLE, clearing resp_valid, resp_rdata, resp_err on that edge.
REQ-025 SHALL ignore req_valid and all request inputs outside IDLE (one outstanding transaction, no queueing).
REQ-026 SHALL tolerate resp_ready held high permanently (response lasts exactly one cycle) and resp_ready low for any number of cycles (indefinite stall, no data change).
REQ-027 SHALL treat out-of-range parameter values as a static elaboration error.

Reset
REQ-028 SHALL, on rst_n low, immediately force FSM to IDLE, counter to 0, resp_valid 0, resp_rdata 0, resp_err 0, req_ready 1 after release.
REQ-029 SHALL not reset memory contents; a write committed before a mid-transaction reset SHALL persist, and the pending response SHALL be discarded.

Verification
REQ-030 SHALL pass: write 0xDEADBEEF @0x10 (WR_LATENCY=1) -> resp_valid one cycle after acceptance, resp_err=0, resp_rdata=0; then read @0x10 (RD_LATENCY=2) -> resp_valid 2 cycles after acceptance, resp_rdata=0xDEADBEEF.
REQ-031 SHALL pass: read @0x13 -> resp_err=1, resp_rdata=0; write 0x1 @0x1000 with DEPTH_WORDS=1024 -> resp_err=1, word 0 unchanged on later read.
REQ-032 SHALL pass: resp_ready held low 5 cycles in RESP -> resp_valid, resp_rdata stable, req_ready=0, new req_valid ignored; release -> IDLE next cycle.
REQ-033 SHALL pass: rst_n pulsed low during WAIT of a write 0x55 @0x20 -> resp_valid never asserts, post-reset read @0x20 returns 0x55.
REQ-034 SHALL pass: back-to-back reads with req_valid and resp_ready constantly high, RD_LATENCY=1 -> one transaction per 2 cycles, correct data each.
